// File: rtl/mdio_master_gen.sv
// MDIO management master: one Clause 22 frame (Clause 45 when MDIO_C45_EN is defined) per start pulse.
// Configurable MDC divider and preamble length; returns captured read data with data_valid.
module mdio_master_gen #(
   parameter int CLK_DIV      = 2,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdio_start,
   input  logic [31:0] t_data,
   input  logic        mdio_in,
   output logic        mdc,
   output logic        mdio_out,
   output logic        mdio_oe,
   output logic [15:0] rd_data,
   output logic        data_valid,
   output logic        busy,
   output logic        done,
   output logic        frame_err
);

   localparam int PW = $clog2(2 * CLK_DIV);
   localparam logic [PW-1:0] PH_LAST   = PW'(2 * CLK_DIV - 1);
   localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_RISE   = PW'(CLK_DIV);
   localparam logic [5:0]    PRE_LAST  = 6'(PREAMBLE_LEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DAT} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [31:0]   frame_q, frame_d;
   logic [15:0]   shift_q, shift_d;
   logic          rd_q, rd_d;
   logic          out_q, out_d;
   logic          oe_q, oe_d;
   logic [15:0]   rd_data_q, rd_data_d;
   logic          dv_q, dv_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;

   logic [1:0] st, op;
   logic       c22_ok, frame_ok, frame_rd, phase_end;

   assign st     = t_data[31:30];
   assign op     = t_data[29:28];
   assign c22_ok = (st == 2'b01) && ((op == 2'b01) || (op == 2'b10));

`ifdef MDIO_C45_EN
   // Clause 45: both read-type opcodes (post-read-increment and read) use read timing
   assign frame_ok = c22_ok || (st == 2'b00);
   assign frame_rd = (st == 2'b01) ? (op == 2'b10) : op[1];
`else
   assign frame_ok = c22_ok;
   assign frame_rd = (op == 2'b10);
`endif

   assign phase_end = (phase_q == PH_LAST);

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      frame_d   = frame_q;
      shift_d   = shift_q;
      rd_d      = rd_q;
      out_d     = out_q;
      oe_d      = oe_q;
      rd_data_d = rd_data_q;
      dv_d      = 1'b0;
      done_d    = 1'b0;
      ferr_d    = 1'b0;

      if (state_q == S_IDLE) begin
         if (mdio_start) begin
            if (frame_ok) begin
               frame_d = t_data;
               rd_d    = frame_rd;
               phase_d = '0;
               cnt_d   = '0;
               oe_d    = 1'b1;
               if (PREAMBLE_LEN > 0) begin
                  state_d = S_PRE;
                  out_d   = 1'b1;
               end else begin
                  state_d = S_HDR;
                  out_d   = t_data[31];
               end
            end else begin
               ferr_d = 1'b1;
            end
         end
      end else begin
         phase_d = phase_end ? '0 : phase_q + 1'b1;
         // PHY data is taken on the edge that raises MDC
         if (state_q == S_DAT && rd_q && phase_q == PH_SAMPLE)
            shift_d = {shift_q[14:0], mdio_in};

         if (phase_end) begin
            cnt_d = cnt_q + 6'd1;
            case (state_q)
               S_PRE: begin
                  if (cnt_q == PRE_LAST) begin
                     state_d = S_HDR;
                     cnt_d   = '0;
                     out_d   = frame_q[31];
                  end
               end
               S_HDR: begin
                  frame_d = frame_q << 1;
                  out_d   = frame_q[30];
                  if (cnt_q == 6'd13) begin
                     state_d = S_TA;
                     cnt_d   = '0;
                     oe_d    = !rd_q;
                     out_d   = !rd_q & frame_q[30];
                  end
               end
               S_TA: begin
                  frame_d = frame_q << 1;
                  out_d   = !rd_q & frame_q[30];
                  if (cnt_q == 6'd1) begin
                     state_d = S_DAT;
                     cnt_d   = '0;
                  end
               end
               S_DAT: begin
                  if (cnt_q == 6'd15) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                     out_d   = 1'b0;
                     oe_d    = 1'b0;
                     done_d  = 1'b1;
                     if (rd_q) begin
                        dv_d      = 1'b1;
                        rd_data_d = shift_q;
                     end
                  end else begin
                     frame_d = frame_q << 1;
                     out_d   = !rd_q & frame_q[30];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         cnt_q     <= '0;
         frame_q   <= '0;
         shift_q   <= '0;
         rd_q      <= 1'b0;
         out_q     <= 1'b0;
         oe_q      <= 1'b0;
         rd_data_q <= '0;
         dv_q      <= 1'b0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
         frame_q   <= frame_d;
         shift_q   <= shift_d;
         rd_q      <= rd_d;
         out_q     <= out_d;
         oe_q      <= oe_d;
         rd_data_q <= rd_data_d;
         dv_q      <= dv_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign mdc        = busy && (phase_q >= PH_RISE);
   assign mdio_out   = out_q;
   assign mdio_oe    = oe_q;
   assign rd_data    = rd_data_q;
   assign data_valid = dv_q;
   assign done       = done_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_mdio_master_gen.sv
// Bench for mdio_master_gen: two instances (CLK_DIV=2/PRE=32 and CLK_DIV=1/PRE=0) checked
// cycle by cycle against a bit-list model of the frame, plus table vectors and reset/overlap cases.
module tb_mdio_master_gen;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start_s [2];
   logic [31:0] td_s    [2];
   logic        mdin_s  [2];
   logic        mdc_s   [2];
   logic        mout_s  [2];
   logic        moe_s   [2];
   logic [15:0] rd_s    [2];
   logic        dv_s    [2];
   logic        busy_s  [2];
   logic        done_s  [2];
   logic        ferr_s  [2];

   mdio_master_gen #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_slow (
      .clk(clk), .reset(reset), .mdio_start(start_s[0]), .t_data(td_s[0]), .mdio_in(mdin_s[0]),
      .mdc(mdc_s[0]), .mdio_out(mout_s[0]), .mdio_oe(moe_s[0]), .rd_data(rd_s[0]),
      .data_valid(dv_s[0]), .busy(busy_s[0]), .done(done_s[0]), .frame_err(ferr_s[0]));

   mdio_master_gen #(.CLK_DIV(1), .PREAMBLE_LEN(0)) u_fast (
      .clk(clk), .reset(reset), .mdio_start(start_s[1]), .t_data(td_s[1]), .mdio_in(mdin_s[1]),
      .mdc(mdc_s[1]), .mdio_out(mout_s[1]), .mdio_oe(moe_s[1]), .rd_data(rd_s[1]),
      .data_valid(dv_s[1]), .busy(busy_s[1]), .done(done_s[1]), .frame_err(ferr_s[1]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic model_is_read(input logic [31:0] fr);
`ifdef MDIO_C45_EN
      if (fr[31:30] == 2'b00) return fr[29];
`endif
      return (fr[31:30] == 2'b01) && (fr[29:28] == 2'b10);
   endfunction

   // Frame model: preamble ones, then the 32 frame bits MSB first; reads release the pad after 14 bits.
   task automatic run_frame(input int idx, input logic [31:0] fr, input logic [15:0] phy,
                            input int mid, input string tag);
      int   d, p, n, len, bad, first_bad, k, f;
      logic rd;
      logic exp_out [0:127];
      logic exp_oe  [0:127];
      logic phy_bit [0:127];
      d   = (idx == 0) ? 2 : 1;
      p   = (idx == 0) ? 32 : 0;
      n   = p + 32;
      len = n * 2 * d;
      rd  = model_is_read(fr);
      for (int i = 0; i < n; i++) begin
         if (i < p) begin
            exp_out[i] = 1'b1;
            exp_oe[i]  = 1'b1;
            phy_bit[i] = 1'($urandom_range(0, 1));
         end else begin
            f          = i - p;
            exp_oe[i]  = !rd || (f < 14);
            exp_out[i] = exp_oe[i] ? fr[31-f] : 1'b0;
            if (f >= 16)      phy_bit[i] = phy[31-f];
            else if (f == 14) phy_bit[i] = 1'b1;
            else if (f == 15) phy_bit[i] = 1'b0;
            else              phy_bit[i] = 1'($urandom_range(0, 1));
         end
      end
      start_s[idx] = 1'b1;
      td_s[idx]    = fr;
      bad          = 0;
      first_bad    = -1;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         start_s[idx] = (c == mid);
         if (c == mid) td_s[idx] = {4'b0110, ~fr[27:0]};
         k = c / (2 * d);
         mdin_s[idx] = phy_bit[k];
         if (busy_s[idx] !== 1'b1 || mdc_s[idx] !== ((c % (2 * d)) >= d) ||
             mout_s[idx] !== exp_out[k] || moe_s[idx] !== exp_oe[k] ||
             done_s[idx] !== 1'b0 || dv_s[idx] !== 1'b0 || ferr_s[idx] !== 1'b0) begin
            bad++;
            if (first_bad < 0) first_bad = c;
         end
      end
      check({tag, "_wave_bad_cycles"}, 32'(bad), 32'd0);
      if (bad > 0) $display("  %s: first deviating cycle %0d", tag, first_bad);
      @(negedge clk);
      start_s[idx] = 1'b0;
      mdin_s[idx]  = 1'b0;
      check({tag, "_end_busy_mdc_oe"}, {29'd0, busy_s[idx], mdc_s[idx], moe_s[idx]}, 32'd0);
      check({tag, "_done"}, {31'd0, done_s[idx]}, 32'd1);
      check({tag, "_data_valid"}, {31'd0, dv_s[idx]}, {31'd0, rd});
      if (rd) check({tag, "_rd_data"}, {16'd0, rd_s[idx]}, {16'd0, phy});
      $display("frame %s idx=%0d t_data=%h read=%0d rd_data=%h", tag, idx, fr, rd, rd_s[idx]);
   endtask

   task automatic err_frame(input int idx, input logic [31:0] fr, input string tag);
      start_s[idx] = 1'b1;
      td_s[idx]    = fr;
      @(negedge clk);
      start_s[idx] = 1'b0;
      check({tag, "_frame_err"}, {31'd0, ferr_s[idx]}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy_s[idx]}, 32'd0);
      @(negedge clk);
      check({tag, "_quiet"}, {28'd0, ferr_s[idx], busy_s[idx], mdc_s[idx], moe_s[idx]}, 32'd0);
      $display("reject %s t_data=%h frame_err_seen", tag, fr);
   endtask

   typedef struct {
      logic [31:0] fr;
      logic        exp_err;
      logic [15:0] phy;
      string       tag;
   } vec_t;

   vec_t tbl [6];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   bad;
      int   idx;
      logic rd;
      logic [31:0] fr;

      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         td_s[i]    = '0;
         mdin_s[i]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++)
         check($sformatf("reset_state_%0d", i),
               {9'd0, mdc_s[i], mout_s[i], moe_s[i], rd_s[i], dv_s[i], busy_s[i], done_s[i], ferr_s[i]},
               32'd0);
      reset = 1'b0;
      @(negedge clk);

      tbl[0] = '{32'h5AB87652, 1'b0, 16'h0000, "spec_write"};
      tbl[1] = '{32'h6AB8AAAA, 1'b0, 16'hA5A5, "spec_read"};
      tbl[2] = '{32'hC0000000, 1'b1, 16'h0000, "st11"};
      tbl[3] = '{32'h4AB80000, 1'b1, 16'h0000, "st01_op00"};
      tbl[4] = '{32'h7AB80000, 1'b1, 16'h0000, "st01_op11"};
`ifdef MDIO_C45_EN
      tbl[5] = '{32'h0AB80000, 1'b0, 16'h1234, "st00_c45"};
`else
      tbl[5] = '{32'h0AB80000, 1'b1, 16'h1234, "st00_c22"};
`endif
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].exp_err) err_frame(0, tbl[i].fr, tbl[i].tag);
         else                run_frame(0, tbl[i].fr, tbl[i].phy, -1, tbl[i].tag);
      end
      // rd_data holds 0xA5A5 from the spec read above, so clearing by reset is visible
      run_frame(0, 32'h6AB8AAAA, 16'hA5A5, -1, "read_again");
      run_frame(0, 32'h5AB87652, 16'h0000, 100, "midstart");

      start_s[0] = 1'b1;
      td_s[0]    = 32'h6AB8AAAA;
      repeat (40 * 4 + 1) begin
         @(negedge clk);
         start_s[0] = 1'b0;
         mdin_s[0]  = 1'($urandom_range(0, 1));
      end
      check("rst_midframe_busy", {31'd0, busy_s[0]}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rst_async_outputs",
            {9'd0, mdc_s[0], mout_s[0], moe_s[0], rd_s[0], dv_s[0], busy_s[0], done_s[0], ferr_s[0]},
            32'd0);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (done_s[0] || dv_s[0] || busy_s[0]) bad++;
      end
      check("rst_no_done_after", 32'(bad), 32'd0);
      $display("reset mid-read applied at bit 40");
      run_frame(0, 32'h5AB87652, 16'h0000, -1, "post_reset_write");

      run_frame(1, 32'h5AB87652, 16'h0000, -1, "fast_write");
      run_frame(1, 32'h6AB8AAAA, 16'h5A3C, -1, "fast_read");

      for (int i = 0; i < 16; i++) begin
         idx = int'($urandom_range(0, 1));
         rd  = 1'($urandom_range(0, 1));
         fr  = {2'b01, rd ? 2'b10 : 2'b01, 28'($urandom)};
         run_frame(idx, fr, 16'($urandom), -1, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
